// File: rtl/cascade_ctr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cascade_ctr_pkg : state and count-mode encodings for cascade_ctr_bench
// Revision: 1.0
// ---------------------------------------------------------------------------
package cascade_ctr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_WRAP = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_LFSR = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

endpackage
`default_nettype wire

// File: rtl/cascade_ctr_bench_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cascade_ctr_bench_if : control inputs and observation outputs of the counter
// Revision: 1.0
// ---------------------------------------------------------------------------
interface cascade_ctr_bench_if #(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 3
) ();
  logic                      clr;
  logic                      en;
  cascade_ctr_pkg::mode_e    mode;
  logic [WIDTH*NUM_CH-1:0]   q;
  logic [NUM_CH-1:0]         tc;
  logic                      ovf;
  cascade_ctr_pkg::state_e   state;

  modport master (output clr, en, mode, input q, tc, ovf, state);
  modport slave  (input clr, en, mode, output q, tc, ovf, state);
endinterface
`default_nettype wire

// File: rtl/cascade_ctr_bench_ctr_channel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ctr_channel : one WIDTH-bit up/down/LFSR/hold counter with terminal flag
// Revision: 1.0
// ---------------------------------------------------------------------------
module ctr_channel
  import cascade_ctr_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 4'b1001
) (
  input  wire logic             ck,
  input  wire logic             rst,
  input  wire logic             clr,
  input  wire logic             step,
  input  wire mode_e            mode,
  output logic [WIDTH-1:0]      q,
  output logic                  term
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_next = r_q;
    unique case (mode)
      MODE_UP:   w_next = r_q + c_one;
      MODE_DOWN: w_next = r_q - c_one;
      // all-zero is a lockup state for the shift register, so kick it to 1
      MODE_LFSR: w_next = (r_q == '0) ? c_one
                                      : {r_q[WIDTH-2:0], ^(r_q & LFSR_TAPS)};
      default:   w_next = r_q;
    endcase
  end

  always_comb begin
    term = 1'b0;
    unique case (mode)
      MODE_UP:   term = &r_q;
      MODE_DOWN: term = (r_q == '0);
      MODE_LFSR: term = (r_q == c_one);
      default:   term = 1'b0;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (step) begin
      r_q <= w_next;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/cascade_ctr_bench.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cascade_ctr_bench : NUM_CH cascaded counter channels with run/wrap control
// Revision: 1.0
// ---------------------------------------------------------------------------
module cascade_ctr_bench
  import cascade_ctr_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               NUM_CH    = 3,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 4'b1001
) (
  input wire logic          ck,
  input wire logic          rst,
  cascade_ctr_bench_if.slave bus
);

  logic [NUM_CH-1:0] w_term;
  logic [NUM_CH-1:0] w_ch_step;
  logic              w_step;
  logic              w_carry;
  state_e            r_state;
  logic              r_ovf;

  // the IDLE->RUN edge itself never counts, so only RUN/WRAP may step
  assign w_step  = ((r_state == ST_RUN) || (r_state == ST_WRAP)) &&
                   bus.en && !bus.clr && (bus.mode != MODE_HOLD);
  assign w_carry = w_step & (&w_term);

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      if (i == 0) begin : g_first
        assign w_ch_step[i] = w_step;
      end else begin : g_rest
        assign w_ch_step[i] = w_step & (&w_term[i-1:0]);
      end

      ctr_channel #(
        .WIDTH     (WIDTH),
        .LFSR_TAPS (LFSR_TAPS)
      ) u_ch (
        .ck   (ck),
        .rst  (rst),
        .clr  (bus.clr),
        .step (w_ch_step[i]),
        .mode (bus.mode),
        .q    (bus.q[i*WIDTH +: WIDTH]),
        .term (w_term[i])
      );
    end
  endgenerate

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ovf   <= 1'b0;
    end else if (bus.clr) begin
      r_state <= ST_IDLE;
      r_ovf   <= 1'b0;
    end else begin
      if (w_carry) begin
        r_ovf <= 1'b1;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (bus.en) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!bus.en)      r_state <= ST_IDLE;
          else if (w_carry) r_state <= ST_WRAP;
        end
        ST_WRAP: begin
          if (w_carry)     r_state <= ST_WRAP;
          else if (bus.en) r_state <= ST_RUN;
          else             r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.tc    = (r_state == ST_IDLE) ? '0 : w_term;
  assign bus.ovf   = r_ovf;
  assign bus.state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_cascade_ctr_bench.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cascade_ctr_bench : directed stimulus with a queued-expectation scoreboard
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_cascade_ctr_bench;
  import cascade_ctr_pkg::*;

  logic ck  = 1'b0;
  logic rst = 1'b1;
  always #5 ck = ~ck;

  cascade_ctr_bench_if #(.WIDTH(4), .NUM_CH(3)) bus ();

  cascade_ctr_bench #(
    .WIDTH     (4),
    .NUM_CH    (3),
    .LFSR_TAPS (4'b1001)
  ) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [17:0] sb_q[$];
  string       sb_n[$];
  event        probe;

  task automatic push_exp(input logic [11:0] q, input logic [2:0] tc,
                          input logic ovf, input logic [1:0] st, input string name);
    sb_q.push_back({q, tc, ovf, st});
    sb_n.push_back(name);
  endtask

  // inputs change just after the falling edge, so they are stable through
  // both the next rising edge and the monitor sample on the falling edge after
  task automatic apply(input logic clr, input logic en, input mode_e mode);
    @(negedge ck);
    #1;
    bus.clr  = clr;
    bus.en   = en;
    bus.mode = mode;
    @(posedge ck);
    #1;
  endtask

  task automatic run(input int n, input mode_e mode);
    repeat (n) apply(1'b0, 1'b1, mode);
  endtask

  initial begin : monitor
    logic [17:0] e;
    logic [17:0] a;
    string       nm;
    forever begin
      @(negedge ck or probe);
      while (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        nm = sb_n.pop_front();
        a  = {bus.q, bus.tc, bus.ovf, bus.state};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL %s: got q=%h tc=%b ovf=%b state=%b, want q=%h tc=%b ovf=%b state=%b",
                   nm, a[17:6], a[5:3], a[2], a[1:0], e[17:6], e[5:3], e[2], e[1:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  initial begin : stim
    bus.clr  = 1'b0;
    bus.en   = 1'b0;
    bus.mode = MODE_UP;

    @(posedge ck);
    #1;
    push_exp(12'h000, 3'b000, 1'b0, ST_IDLE, "reset");
    @(negedge ck);
    #1;
    rst = 1'b0;

    // up count through full wrap
    apply(1'b0, 1'b1, MODE_UP);
    push_exp(12'h000, 3'b000, 1'b0, ST_RUN, "idle2run");
    run(16, MODE_UP);
    push_exp(12'h010, 3'b000, 1'b0, ST_RUN, "up16");
    run(4079, MODE_UP);
    push_exp(12'hFFF, 3'b111, 1'b0, ST_RUN, "up4095");
    run(1, MODE_UP);
    push_exp(12'h000, 3'b000, 1'b1, ST_WRAP, "upwrap");
    run(1, MODE_UP);
    push_exp(12'h001, 3'b000, 1'b1, ST_RUN, "wrap_exit");

    // clear beats enable and sticky overflow
    apply(1'b1, 1'b1, MODE_UP);
    push_exp(12'h000, 3'b000, 1'b0, ST_IDLE, "clr");
    apply(1'b0, 1'b1, MODE_UP);
    push_exp(12'h000, 3'b000, 1'b0, ST_RUN, "clr_nocount");

    // down borrow from zero
    run(1, MODE_DOWN);
    push_exp(12'hFFF, 3'b000, 1'b1, ST_WRAP, "down_borrow");
    run(1, MODE_DOWN);
    push_exp(12'hFFE, 3'b000, 1'b1, ST_RUN, "down_run");

    // hold then resume up
    run(5, MODE_HOLD);
    push_exp(12'hFFE, 3'b000, 1'b1, ST_RUN, "hold5");
    run(1, MODE_UP);
    push_exp(12'hFFF, 3'b111, 1'b1, ST_RUN, "resume");

    // LFSR: channel 0 runs 0,1,3,7,F,E; channel 1 steps once (when ch0==1)
    apply(1'b1, 1'b0, MODE_LFSR);
    push_exp(12'h000, 3'b000, 1'b0, ST_IDLE, "lfsr_clr");
    apply(1'b0, 1'b1, MODE_LFSR);
    push_exp(12'h000, 3'b000, 1'b0, ST_RUN, "lfsr_start");
    run(1, MODE_LFSR);
    push_exp(12'h001, 3'b001, 1'b0, ST_RUN, "lfsr1");
    run(1, MODE_LFSR);
    push_exp(12'h013, 3'b010, 1'b0, ST_RUN, "lfsr2");
    run(1, MODE_LFSR);
    push_exp(12'h017, 3'b010, 1'b0, ST_RUN, "lfsr3");
    run(1, MODE_LFSR);
    push_exp(12'h01F, 3'b010, 1'b0, ST_RUN, "lfsr4");
    run(1, MODE_LFSR);
    push_exp(12'h01E, 3'b010, 1'b0, ST_RUN, "lfsr5");
    run(1, MODE_HOLD);
    push_exp(12'h01E, 3'b000, 1'b0, ST_RUN, "lfsr_hold");

    // asynchronous reset in the middle of a cycle
    apply(1'b1, 1'b0, MODE_UP);
    apply(1'b0, 1'b1, MODE_UP);
    run(679, MODE_UP);
    push_exp(12'h2A7, 3'b000, 1'b0, ST_RUN, "pre_reset");
    @(negedge ck);
    #1;
    rst = 1'b1;
    push_exp(12'h000, 3'b000, 1'b0, ST_IDLE, "async_rst");
    #1;
    ->probe;
    @(negedge ck);
    #1;
    rst = 1'b0;
    apply(1'b0, 1'b0, MODE_UP);
    push_exp(12'h000, 3'b000, 1'b0, ST_IDLE, "release_idle");
    apply(1'b0, 1'b1, MODE_UP);
    push_exp(12'h000, 3'b000, 1'b0, ST_RUN, "rerun");

    @(negedge ck);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cascade_ctr_bench.md
Name: cascade_ctr_bench

Overview:
- Parametrised sequential test block: NUM_CH cascaded WIDTH-bit counter channels plus a small run/wrap controller with a sticky overflow flag.
- Selectable count modes: up, down, LFSR, hold.
- Sits beside the fixed gate-level sequential circuits as a scalable ATPG/fault-simulation target.
- Flop count scales as NUM_CH*WIDTH+3.

Parameters:
- WIDTH, 4, bits per channel (>=3)
- NUM_CH, 3, number of cascaded channels (>=1)
- LFSR_TAPS, 4'b1001, WIDTH-bit feedback tap mask used in LFSR mode

Ports:
- CK  in  1  clock, rising edge
- RST  in  1  reset
- CLR  in  1  synchronous clear; priority over all except RST
- EN  in  1  run enable
- MODE  in  2  00 up, 01 down, 10 LFSR, 11 hold
- Q  out  WIDTH*NUM_CH  channel values, channel 0 in LSBs
- TC  out  NUM_CH  per-channel terminal flag
- OVF  out  1  sticky carry/borrow-out of last channel
- STATE  out  2  controller state: 00 IDLE, 01 RUN, 10 WAIT-free WRAP

Behaviour:
- One clock CK; reset RST is asynchronous, active-high.
- On RST:
  - Q=0, OVF=0, STATE=IDLE.
  - TC=0, since TC is forced 0 in IDLE.
  - Takes effect immediately, including mid-count.
- CLR=1 at an edge:
  - Q=0, OVF=0, STATE=IDLE next cycle.
  - Overrides EN, MODE and any pending wrap.
- FSM, evaluated when CLR=0:
  - IDLE->RUN when EN=1.
  - RUN->IDLE when EN=0.
  - RUN->WRAP when a last-channel carry-out occurs at this edge.
  - WRAP lasts exactly one cycle, then goes to RUN if EN=1, else IDLE.
  - WRAP->WRAP is impossible unless another carry-out occurs; if it does, stay in WRAP.
- Step enable:
  - A count step occurs at an edge only when the current STATE is RUN or WRAP, EN=1, CLR=0 and MODE!=11.
  - The IDLE->RUN edge does not count. First step is the second enabled edge.
- Per-channel next value:
  - up: q+1 mod 2^WIDTH.
  - down: q-1 mod 2^WIDTH.
  - LFSR: {q[WIDTH-2:0], ^(q & LFSR_TAPS)}; if q==0, next value is 1 (lockup escape).
  - hold: q unchanged.
- Terminal condition term(i):
  - up: q==all ones.
  - down: q==0.
  - LFSR: q==1.
  - hold: 0.
- Cascade:
  - Channel 0 steps on every step.
  - Channel i steps when term(0..i-1) are all 1.
  - All channels update on the same edge; the carry ripples combinationally.
- Carry-out: step occurs and term(0..NUM_CH-1) are all 1.
  - Sets OVF, which holds until CLR or RST.
  - Drives the WRAP transition.
- TC[i] = term(i) from the registered Q and the current MODE, gated to 0 when STATE=IDLE. It is combinational from registered state.
- MODE change mid-run:
  - Takes effect on the next step.
  - Q values are retained and no clear is implied.
  - TC re-evaluates in the same cycle.
- Q, OVF and STATE are direct flop outputs with no combinational path from inputs. TC depends combinationally on MODE.

Decomposition:
- Package cascade_ctr_pkg holds:
  - STATE encodings (IDLE, RUN, WRAP).
  - MODE encodings (UP, DOWN, LFSR, HOLD).
- One sub-module, ctr_channel:
  - WIDTH-bit register with step, MODE, term output and LFSR lockup escape.
  - Instantiated NUM_CH times.
- The top level holds the FSM, carry chain and OVF.

Test Plan:
- Async reset (defaults W=4, N=3): count to Q=0x2A7, assert RST between edges -> Q=0, TC=0, OVF=0, STATE=00 before the next edge; release -> IDLE.
- Up wrap:
  - EN=1, MODE=00 from 0: after 16 steps Q=0x010.
  - After 4095 steps Q=0xFFF with TC=3'b111.
  - Step 4096 -> Q=0x000, OVF=1, STATE=10 for one cycle, then 01.
- Down borrow: EN=1, MODE=01 from 0 -> first step Q=0xFFF, OVF=1, STATE=WRAP; next step Q=0xFFE, STATE=RUN.
- LFSR: MODE=10, TAPS=4'b1001 from 0 -> channel 0 sequence 0,1,3,7,F,E; channel 1 steps only when channel 0==1.
- CLR priority: mid-run with OVF=1, assert CLR and EN together -> next edge Q=0, OVF=0, STATE=IDLE; following edge RUN with no count.
- Hold and mode switch:
  - MODE=11 for 5 cycles -> Q frozen, STATE=RUN, TC=0.
  - Switch to 00 -> counting resumes from the frozen value +1.
